// File: rtl/gf_pkg.sv
// Shared types and constants for the sequential GF(2^N) multiplier.
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RED  = 2'd2,
        DONE = 2'd3
    } gf_state_e;

    localparam logic [7:0] GF_POLY_DEFAULT = 8'h1B;

endpackage

// File: rtl/gf_step.sv
// One conditional shift-XOR step, shared by the multiply and reduce phases.
module gf_step #(
    parameter int W = 16
) (
    input  logic         i_sel,
    input  logic [W-1:0] i_opnd,
    input  logic [W-1:0] i_acc,
    output logic [W-1:0] o_acc
);

    assign o_acc = i_sel ? (i_acc ^ i_opnd) : i_acc;

endmodule

// File: rtl/gf_mult_seq.sv
// Bit-serial carry-less multiplier with optional reduction modulo {1,POLY}.
// N cycles of shift-XOR multiply, then N optional reduction cycles from the top bit down.
module gf_mult_seq
    import gf_pkg::*;
#(
    parameter int             N    = 8,
    parameter logic [N-1:0]   POLY = N'(GF_POLY_DEFAULT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
    output logic           busy
);

    localparam int CW  = $clog2(2*N) + 1;
    localparam int IW  = $clog2(N);
    localparam int IW1 = IW + 1;

    gf_state_e        r_state, w_state_nxt;
    logic [N-1:0]     r_a, r_b;
    logic             r_mode;
    logic [2*N-1:0]   r_acc, r_result;
    logic [CW-1:0]    r_cnt;

    logic [IW-1:0]    w_idx, w_rsh;
    logic [IW1-1:0]   w_ridx;
    logic             w_last, w_sel;
    logic [2*N-1:0]   w_opnd, w_acc_nxt;

    assign w_idx  = r_cnt[IW-1:0];
    assign w_last = (r_cnt == CW'(N-1));
    // Reduction walks acc bit k = 2N-1-cnt, so the polynomial shift is k-N = N-1-cnt.
    assign w_ridx = IW1'(2*N-1) - {1'b0, w_idx};
    assign w_rsh  = IW'(N-1) - w_idx;

    always_comb begin
        w_sel  = 1'b0;
        w_opnd = '0;
        if (r_state == MUL) begin
            w_sel  = r_b[w_idx];
            w_opnd = {{N{1'b0}}, r_a} << w_idx;
        end else if (r_state == RED) begin
            w_sel  = r_acc[w_ridx];
            w_opnd = {{(N-1){1'b0}}, 1'b1, POLY} << w_rsh;
        end
    end

    gf_step #(.W(2*N)) u_step (
        .i_sel  (w_sel),
        .i_opnd (w_opnd),
        .i_acc  (r_acc),
        .o_acc  (w_acc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid)  w_state_nxt = MUL;
            MUL:  if (w_last)    w_state_nxt = r_mode ? RED : DONE;
            RED:  if (w_last)    w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default:             w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a    <= a;
                    r_b    <= b;
                    r_mode <= mode;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                end
                MUL: begin
                    r_acc <= w_acc_nxt;
                    if (w_last) begin
                        r_cnt <= '0;
                        if (!r_mode) r_result <= w_acc_nxt;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RED: begin
                    r_acc <= w_acc_nxt;
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_result <= w_acc_nxt;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: if (out_ready) r_result <= '0;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign result    = r_result;

endmodule

// File: tb/tb_gf_mult_seq.sv
// Directed and random checks of gf_mult_seq (N=8, POLY=0x1B) against a peasant-style GF model.
module tb_gf_mult_seq;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic [N-1:0]  a, b;
    logic [2*N-1:0] result;

    int n_pass = 0;
    int n_tot  = 0;

    gf_mult_seq #(.N(N), .POLY(8'h1B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Carry-less product, or field product via repeated xtime.
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic m);
        logic [15:0] p;
        logic [7:0]  r, t;
        logic        c;
        p = '0;
        for (int i = 0; i < 8; i++) if (y[i]) p ^= (16'(x) << i);
        if (!m) return p;
        r = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) r ^= t;
            c = t[7];
            t = t << 1;
            if (c) t ^= 8'h1B;
        end
        return {8'h00, r};
    endfunction

    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tm, input logic [15:0] exp, input int hold);
        int   lat;
        logic zero_ok;
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        a = ta; b = tb_; mode = tm; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
        lat = 1;
        zero_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (result !== '0 || !busy || in_ready) zero_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_idle_outs"}, {31'd0, zero_ok}, 32'd1);
        chk({tag, "_lat"}, lat, tm ? 2*N+1 : N+1);
        chk({tag, "_res"}, {16'd0, result}, {16'd0, exp});
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({tag, "_hold"}, {14'd0, out_valid, in_ready, result}, {14'd0, 1'b1, 1'b0, exp});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_post"}, {14'd0, out_valid, in_ready, result}, {14'd0, 1'b0, 1'b1, 16'd0});
    endtask

    initial begin
        int t_acc [$];
        logic [7:0] ra, rb;
        logic       rm;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = 1'b0;
        #2;
        chk("reset_outs", {13'd0, in_ready, out_valid, busy, result}, {13'd0, 3'b100, 16'd0});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op("v57x83_m0", 8'h57, 8'h83, 1'b0, 16'h2B79, 0);
        run_op("v57x83_m1", 8'h57, 8'h83, 1'b1, 16'h00C1, 0);
        run_op("v02x80_m1", 8'h02, 8'h80, 1'b1, 16'h001B, 0);
        run_op("vFFxFF_m0", 8'hFF, 8'hFF, 1'b0, 16'h5555, 0);
        run_op("v00xA5_m0", 8'h00, 8'hA5, 1'b0, 16'h0000, 0);
        run_op("v00xA5_m1", 8'h00, 8'hA5, 1'b1, 16'h0000, 0);
        run_op("vA5x00_m1", 8'hA5, 8'h00, 1'b1, 16'h0000, 0);
        run_op("hold5",     8'h57, 8'h83, 1'b1, 16'h00C1, 5);

        // Reset in the 4th MUL cycle must abort the op without any output handshake.
        a = 8'h11; b = 8'h22; mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_async", {13'd0, in_ready, out_valid, busy, result}, {13'd0, 3'b100, 16'd0});
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 25; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen = 1'b1;
            end
            chk("rst_no_valid", {31'd0, seen}, 32'd0);
        end
        run_op("post_rst", 8'h57, 8'h13, 1'b1, 16'h00FE, 0);

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb, rm, ref_mul(ra, rb, rm), int'($urandom_range(0, 3)));
        end

        // Back-to-back: with both handshakes held high, accepts repeat every N+2 / 2N+2 cycles.
        for (int m = 0; m < 2; m++) begin
            t_acc.delete();
            mode = m[0]; a = 8'h35; b = 8'hC7; out_ready = 1'b1; in_valid = 1'b1;
            for (int t = 0; t < 120 && t_acc.size() < 3; t++) begin
                if (in_ready) t_acc.push_back(t);
                if (t_acc.size() == 3) in_valid = 1'b0;
                else begin @(posedge clk); #1; end
            end
            in_valid = 1'b0;
            if (t_acc.size() < 3) begin
                chk($sformatf("thru_m%0d_timeout", m), t_acc.size(), 3);
            end else begin
                chk($sformatf("thru_m%0d_a", m), t_acc[1] - t_acc[0], m ? 2*N+2 : N+2);
                chk($sformatf("thru_m%0d_b", m), t_acc[2] - t_acc[1], m ? 2*N+2 : N+2);
            end
            out_ready = 1'b0;
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
